// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: prescaled pixel enable, h/v counters and
// registered sync / active-video / coordinate outputs, all on the system clock.
module vga_timing_gen #(
   parameter int   DIV      = 4,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       pix_en,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] div_cnt;
   logic [9:0]    h;
   logic [9:0]    v;
   logic [9:0]    h_nxt;
   logic [9:0]    v_nxt;
   logic          h_wrap;
   logic          vis_nxt;
   logic          line_start_q;
   logic          frame_start_q;

   assign pix_en = en && (div_cnt == DIV_LAST);
   assign h_wrap = pix_en && (h == H_LAST);

   always_comb begin
      h_nxt = h;
      v_nxt = v;
      if (pix_en) begin
         if (h == H_LAST) begin
            h_nxt = '0;
            v_nxt = (v == V_LAST) ? '0 : v + 10'd1;
         end else begin
            h_nxt = h + 10'd1;
         end
      end
   end

   assign vis_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);

   // Levels are decoded from the next-state counters so they line up with h/v.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt       <= '0;
         h             <= '0;
         v             <= '0;
         hsync         <= ~SYNC_POL;
         vsync         <= ~SYNC_POL;
         video_on      <= 1'b1;
         x             <= '0;
         y             <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         if (en) begin
            div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            h        <= h_nxt;
            v        <= v_nxt;
            hsync    <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync    <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            video_on <= vis_nxt;
            x        <= vis_nxt ? h_nxt : '0;
            y        <= vis_nxt ? v_nxt : '0;
         end
         line_start_q  <= h_wrap;
         frame_start_q <= h_wrap && (v == V_LAST);
      end
   end

   // Pulses are suppressed whenever the generator is paused.
   assign line_start  = line_start_q && en;
   assign frame_start = frame_start_q && en;

endmodule
